// File: rtl/mips_core_pkg.sv
// Core-wide types shared by the thread controller and the logic that consumes its status.
package mips_core_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } ThreadState;

  localparam int unsigned NUM_THREADS = 2;

  function automatic logic other_thread(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/thread_controller_if.sv
// Thread-control status bundle: driven by thread_controller (out), observed by fetch/commit (in).
`include "mips_core.svh"

interface thread_control_ifc;

  logic                   thread_id;
  logic                   thread_switch;
  logic                   current_thread_done;
  logic                   thread_0_done;
  logic                   thread_1_done;
  logic [`ADDR_WIDTH-1:0] thread_resume_pc [2];

  modport out (
    output thread_id,
    output thread_switch,
    output current_thread_done,
    output thread_0_done,
    output thread_1_done,
    output thread_resume_pc
  );

  modport in (
    input thread_id,
    input thread_switch,
    input current_thread_done,
    input thread_0_done,
    input thread_1_done,
    input thread_resume_pc
  );

endinterface

// File: rtl/mips_core.svh
// Core-wide constants: address width and default thread-scheduling timing.
// Included by every file that sizes an address or a thread counter.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH

`define ADDR_WIDTH     32
`define THREAD_MIN_RUN 4
`define THREAD_QUANTUM 64

`endif

// File: rtl/thread_switch_timer.sv
// Run-window and time-slice counters for thread_controller.
// THREAD_QUANTUM_EN builds the time-slice counter; without it quantum_expired is tied low.
`include "mips_core.svh"

module thread_switch_timer #(
  parameter int unsigned MIN_RUN = `THREAD_MIN_RUN,
  parameter int unsigned QUANTUM = `THREAD_QUANTUM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic enable,
  output logic run_ok,
  output logic quantum_expired
);

  localparam int unsigned     RUN_W    = (MIN_RUN > 0) ? $clog2(MIN_RUN + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_LOAD = RUN_W'(MIN_RUN);

  logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;

  // Counts down only while the thread is running and sticks at zero.
  always_comb begin
    run_cnt_next = run_cnt_reg;
    if (reload) begin
      run_cnt_next = RUN_LOAD;
    end else if (enable && (run_cnt_reg != '0)) begin
      run_cnt_next = run_cnt_reg - RUN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_reg <= RUN_LOAD;
    end else begin
      run_cnt_reg <= run_cnt_next;
    end
  end

  assign run_ok = (run_cnt_reg == '0);

`ifdef THREAD_QUANTUM_EN
  localparam int unsigned     QNT_W    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [QNT_W-1:0] QNT_LAST = QNT_W'(QUANTUM - 1);

  logic [QNT_W-1:0] qnt_cnt_reg, qnt_cnt_next;

  assign quantum_expired = enable && (qnt_cnt_reg == QNT_LAST);

  // Wraps on expiry so a thread that cannot be preempted simply starts a new slice.
  always_comb begin
    qnt_cnt_next = qnt_cnt_reg;
    if (reload) begin
      qnt_cnt_next = '0;
    end else if (enable) begin
      qnt_cnt_next = quantum_expired ? '0 : qnt_cnt_reg + QNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qnt_cnt_reg <= '0;
    end else begin
      qnt_cnt_reg <= qnt_cnt_next;
    end
  end
`else
  assign quantum_expired = 1'b0;
`endif

endmodule

// File: rtl/thread_controller.sv
// Two-thread switch controller: selects the active thread, captures its resume PC on a
// switch and tracks completion. Defining THREAD_QUANTUM_EN adds time-slice preemption.
`include "mips_core.svh"

module thread_controller
  import mips_core_pkg::*;
#(
  parameter int unsigned            MIN_RUN    = `THREAD_MIN_RUN,
  parameter int unsigned            QUANTUM    = `THREAD_QUANTUM,
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC_0 = 32'h0000_0000,
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC_1 = 32'h0000_1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [`ADDR_WIDTH-1:0] i_resume_pc,
  input  logic                   i_switch_req,
  input  logic                   i_thread_done,
  input  logic                   i_pipe_stall,
  thread_control_ifc.out         out
);

  ThreadState             state_reg, state_next;
  logic                   thread_id_reg;
  logic                   thread_switch_reg;
  logic [NUM_THREADS-1:0] done_vec;
  logic                   other_done;
  logic                   commit;
  logic                   set_done;
  logic                   run_ok;
  logic                   quantum_expired;

  assign other_done = done_vec[other_thread(thread_id_reg)];

  thread_switch_timer #(
    .MIN_RUN (MIN_RUN),
    .QUANTUM (QUANTUM)
  ) u_timer (
    .clk             (clk),
    .rst_n           (rst_n),
    .reload          (commit),
    .enable          (state_reg == RUN),
    .run_ok          (run_ok),
    .quantum_expired (quantum_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Entry into PEND is only allowed while the other thread is still live, so a
  // commit can never hand the pipeline to a finished thread.
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    set_done   = 1'b0;
    case (state_reg)
      RUN: begin
        if (i_thread_done) begin
          set_done   = 1'b1;
          state_next = other_done ? HALT : PEND;
        end else if (!other_done && ((i_switch_req && run_ok) || quantum_expired)) begin
          state_next = PEND;
        end
      end
      PEND: begin
        set_done = i_thread_done;
        if (!i_pipe_stall) begin
          commit     = 1'b1;
          state_next = RUN;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thread_id_reg     <= 1'b0;
      thread_switch_reg <= 1'b0;
    end else begin
      thread_switch_reg <= commit;
      if (commit) begin
        thread_id_reg <= other_thread(thread_id_reg);
      end
    end
  end

  // Per-thread context: resume PC captured on the commit edge, sticky done flag.
  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
    localparam logic [`ADDR_WIDTH-1:0] RST_PC = (gi == 0) ? RESET_PC_0 : RESET_PC_1;

    logic                   active;
    logic [`ADDR_WIDTH-1:0] pc_reg;
    logic                   done_reg;

    assign active = (thread_id_reg == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pc_reg   <= RST_PC;
        done_reg <= 1'b0;
      end else begin
        if (commit && active) begin
          pc_reg <= i_resume_pc;
        end
        if (set_done && active) begin
          done_reg <= 1'b1;
        end
      end
    end

    assign done_vec[gi]             = done_reg;
    assign out.thread_resume_pc[gi] = pc_reg;
  end

  assign out.thread_id           = thread_id_reg;
  assign out.thread_switch       = thread_switch_reg;
  assign out.current_thread_done = done_vec[thread_id_reg];
  assign out.thread_0_done       = done_vec[0];
  assign out.thread_1_done       = done_vec[1];

endmodule

// File: tb/tb_thread_controller.sv
// Directed bench for thread_controller; status is checked as {id, switch, cur_done, done0, done1}.
// With THREAD_QUANTUM_EN defined only the reset and time-slice scenarios run.
module tb_thread_controller;

`ifdef THREAD_QUANTUM_EN
  localparam int unsigned TB_QUANTUM = 8;
`else
  localparam int unsigned TB_QUANTUM = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] resume_pc = 32'h0;
  logic        switch_req = 1'b0;
  logic        thread_done = 1'b0;
  logic        pipe_stall = 1'b0;

  int checks = 0;
  int failures = 0;

  thread_control_ifc ifc ();

  thread_controller #(
    .MIN_RUN    (4),
    .QUANTUM    (TB_QUANTUM),
    .RESET_PC_0 (32'h0000_0000),
    .RESET_PC_1 (32'h0000_1000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_resume_pc  (resume_pc),
    .i_switch_req (switch_req),
    .i_thread_done(thread_done),
    .i_pipe_stall (pipe_stall),
    .out          (ifc)
  );

  always #5 clk = ~clk;

  logic [4:0] st;
  assign st = {ifc.thread_id, ifc.thread_switch, ifc.current_thread_done,
               ifc.thread_0_done, ifc.thread_1_done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (st !== 5'b00000) begin
      failures++;
      $display("FAIL reset_status: got %b want 00000", st);
    end
    checks++;
    if (ifc.thread_resume_pc[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc0: got %h want 00000000", ifc.thread_resume_pc[0]);
    end
    checks++;
    if (ifc.thread_resume_pc[1] !== 32'h1000) begin
      failures++;
      $display("FAIL reset_pc1: got %h want 00001000", ifc.thread_resume_pc[1]);
    end
    #3 rst_n = 1'b1;
    $display("test_reset: status=%b pc0=%h pc1=%h", st, ifc.thread_resume_pc[0], ifc.thread_resume_pc[1]);
  endtask

`ifndef THREAD_QUANTUM_EN
  task automatic test_idle();
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (st !== 5'b00000) begin
        failures++;
        $display("FAIL idle_status cycle %0d: got %b want 00000", k, st);
      end
    end
    checks++;
    if (ifc.thread_resume_pc[0] !== 32'h0 || ifc.thread_resume_pc[1] !== 32'h1000) begin
      failures++;
      $display("FAIL idle_pcs: got %h/%h want 00000000/00001000",
               ifc.thread_resume_pc[0], ifc.thread_resume_pc[1]);
    end
    $display("test_idle: 10 idle cycles, status=%b", st);
  endtask

  task automatic test_switch();
    switch_req = 1'b1;
    resume_pc  = 32'h40;
    step();
    switch_req = 1'b0;
    checks++;
    if (st !== 5'b00000) begin
      failures++;
      $display("FAIL switch_req_edge: got %b want 00000", st);
    end
    step();
    resume_pc = 32'hDEAD_0000;
    checks++;
    if (st !== 5'b11000) begin
      failures++;
      $display("FAIL switch_pulse: got %b want 11000", st);
    end
    checks++;
    if (ifc.thread_resume_pc[0] !== 32'h40 || ifc.thread_resume_pc[1] !== 32'h1000) begin
      failures++;
      $display("FAIL switch_pcs: got %h/%h want 00000040/00001000",
               ifc.thread_resume_pc[0], ifc.thread_resume_pc[1]);
    end
    step();
    checks++;
    if (st !== 5'b10000) begin
      failures++;
      $display("FAIL switch_single_pulse: got %b want 10000", st);
    end
    $display("test_switch: t0->t1 resume_pc[0]=%h", ifc.thread_resume_pc[0]);
  endtask

  task automatic test_min_run();
    // Requests sampled on the 2nd..4th edges after the switch fall inside the window.
    switch_req = 1'b1;
    resume_pc  = 32'h2000;
    for (int k = 2; k <= 4; k++) begin
      step();
      checks++;
      if (st !== 5'b10000) begin
        failures++;
        $display("FAIL min_run_blocked edge %0d: got %b want 10000", k, st);
      end
    end
    switch_req = 1'b0;
    for (int k = 5; k <= 7; k++) begin
      step();
      checks++;
      if (st !== 5'b10000) begin
        failures++;
        $display("FAIL min_run_not_queued edge %0d: got %b want 10000", k, st);
      end
    end
    switch_req = 1'b1;
    step();
    switch_req = 1'b0;
    checks++;
    if (st !== 5'b10000) begin
      failures++;
      $display("FAIL min_run_accept_edge: got %b want 10000", st);
    end
    step();
    checks++;
    if (st !== 5'b01000) begin
      failures++;
      $display("FAIL min_run_switch: got %b want 01000", st);
    end
    checks++;
    if (ifc.thread_resume_pc[1] !== 32'h2000) begin
      failures++;
      $display("FAIL min_run_pc1: got %h want 00002000", ifc.thread_resume_pc[1]);
    end
    step();
    checks++;
    if (st !== 5'b00000) begin
      failures++;
      $display("FAIL min_run_pulse_end: got %b want 00000", st);
    end
    $display("test_min_run: t1->t0 resume_pc[1]=%h", ifc.thread_resume_pc[1]);
  endtask

  task automatic test_stall();
    repeat (4) step();
    switch_req = 1'b1;
    pipe_stall = 1'b1;
    resume_pc  = 32'h0000_0BAD;
    step();
    switch_req = 1'b0;
    checks++;
    if (st !== 5'b00000) begin
      failures++;
      $display("FAIL stall_pend: got %b want 00000", st);
    end
    for (int k = 1; k <= 3; k++) begin
      resume_pc = 32'hBAD0 + 32'(k);
      step();
      checks++;
      if (st !== 5'b00000) begin
        failures++;
        $display("FAIL stall_hold %0d: got %b want 00000", k, st);
      end
    end
    pipe_stall = 1'b0;
    resume_pc  = 32'h80;
    step();
    checks++;
    if (st !== 5'b11000) begin
      failures++;
      $display("FAIL stall_pulse: got %b want 11000", st);
    end
    checks++;
    if (ifc.thread_resume_pc[0] !== 32'h80 || ifc.thread_resume_pc[1] !== 32'h2000) begin
      failures++;
      $display("FAIL stall_pcs: got %h/%h want 00000080/00002000",
               ifc.thread_resume_pc[0], ifc.thread_resume_pc[1]);
    end
    step();
    checks++;
    if (st !== 5'b10000) begin
      failures++;
      $display("FAIL stall_pulse_end: got %b want 10000", st);
    end
    $display("test_stall: 3 stalled cycles, t0->t1 resume_pc[0]=%h", ifc.thread_resume_pc[0]);
  endtask

  task automatic test_reset_in_pend();
    repeat (4) step();
    switch_req = 1'b1;
    pipe_stall = 1'b1;
    resume_pc  = 32'h5555;
    step();
    switch_req = 1'b0;
    checks++;
    if (st !== 5'b10000) begin
      failures++;
      $display("FAIL abort_pend: got %b want 10000", st);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (st !== 5'b00000) begin
      failures++;
      $display("FAIL abort_async_status: got %b want 00000", st);
    end
    checks++;
    if (ifc.thread_resume_pc[0] !== 32'h0 || ifc.thread_resume_pc[1] !== 32'h1000) begin
      failures++;
      $display("FAIL abort_async_pcs: got %h/%h want 00000000/00001000",
               ifc.thread_resume_pc[0], ifc.thread_resume_pc[1]);
    end
    pipe_stall = 1'b0;
    resume_pc  = 32'h6666;
    repeat (2) step();
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (st !== 5'b00000) begin
        failures++;
        $display("FAIL abort_no_pulse %0d: got %b want 00000", k, st);
      end
    end
    $display("test_reset_in_pend: switch aborted, thread_id=%0b", ifc.thread_id);
  endtask

  task automatic test_done();
    // Run counter is still nonzero here: done must bypass the window and beat the request.
    thread_done = 1'b1;
    switch_req  = 1'b1;
    resume_pc   = 32'h300;
    step();
    thread_done = 1'b0;
    switch_req  = 1'b0;
    checks++;
    if (st !== 5'b00110) begin
      failures++;
      $display("FAIL done0_flag: got %b want 00110", st);
    end
    step();
    checks++;
    if (st !== 5'b11010) begin
      failures++;
      $display("FAIL done0_switch: got %b want 11010", st);
    end
    checks++;
    if (ifc.thread_resume_pc[0] !== 32'h300) begin
      failures++;
      $display("FAIL done0_pc0: got %h want 00000300", ifc.thread_resume_pc[0]);
    end
    step();
    checks++;
    if (st !== 5'b10010) begin
      failures++;
      $display("FAIL done0_pulse_end: got %b want 10010", st);
    end
    thread_done = 1'b1;
    switch_req  = 1'b1;
    step();
    checks++;
    if (st !== 5'b10111) begin
      failures++;
      $display("FAIL done1_halt: got %b want 10111", st);
    end
    resume_pc = 32'hFFFF;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (st !== 5'b10111) begin
        failures++;
        $display("FAIL halt_hold %0d: got %b want 10111", k, st);
      end
    end
    checks++;
    if (ifc.thread_resume_pc[0] !== 32'h300 || ifc.thread_resume_pc[1] !== 32'h1000) begin
      failures++;
      $display("FAIL halt_pcs: got %h/%h want 00000300/00001000",
               ifc.thread_resume_pc[0], ifc.thread_resume_pc[1]);
    end
    thread_done = 1'b0;
    switch_req  = 1'b0;
    $display("test_done: both threads done, halted on thread %0b", ifc.thread_id);
  endtask
`else
  task automatic test_quantum();
    logic exp_id;
    logic exp_sw;
    for (int k = 1; k <= 27; k++) begin
      step();
      exp_sw = ((k % 9) == 0);
      exp_id = ((k / 9) % 2) == 1;
      checks++;
      if (st !== {exp_id, exp_sw, 3'b000}) begin
        failures++;
        $display("FAIL quantum_slice cycle %0d: got %b want %b", k, st, {exp_id, exp_sw, 3'b000});
      end
    end
    thread_done = 1'b1;
    switch_req  = 1'b1;
    step();
    thread_done = 1'b0;
    switch_req  = 1'b0;
    checks++;
    if (st !== 5'b10101) begin
      failures++;
      $display("FAIL quantum_done_req: got %b want 10101", st);
    end
    step();
    checks++;
    if (st !== 5'b01001) begin
      failures++;
      $display("FAIL quantum_done_switch: got %b want 01001", st);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (st !== 5'b00001) begin
        failures++;
        $display("FAIL quantum_wrap %0d: got %b want 00001", k, st);
      end
    end
    $display("test_quantum: 3 slices, done+req single switch, thread_id=%0b", ifc.thread_id);
  endtask
`endif

  initial begin
    test_reset();
`ifndef THREAD_QUANTUM_EN
    test_idle();
    test_switch();
    test_min_run();
    test_stall();
    test_reset_in_pend();
    test_done();
`else
    test_quantum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
